// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs the imem req/ack handshake and a one-entry decode buffer.
// Optional taken-redirect counter enabled by defining PC_FETCH_BRCNT_EN.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        br_valid_i,
    input  logic        branch_i,
    input  logic        cmp_i,
    input  logic [31:0] br_pc_i,
    input  logic [31:0] br_offset_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        flush_o,
    output logic [31:0] taken_cnt_o
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              discard_q, discard_d;
    logic              req_d;
    logic [XLEN-1:0]   addr_d;
    logic              valid_d;
    logic [XLEN-1:0]   instr_d;
    logic [XLEN-1:0]   pc_out_d;
    logic              flush_d;

    logic              redirect;
    logic              consume;
    logic [XLEN-1:0]   target;

    assign redirect = br_valid_i & branch_i & cmp_i & (state_q != ST_BOOT);
    assign consume  = instr_valid_o & ~stall_i;
    assign target   = br_pc_i + (br_offset_i << 2);

    // Next-state and next-output logic; a redirect overrides pc and the buffer last.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        req_d     = imem_req_o;
        addr_d    = imem_addr_o;
        valid_d   = instr_valid_o & ~consume;
        instr_d   = instr_o;
        pc_out_d  = pc_o;
        flush_d   = redirect;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (!redirect && (!instr_valid_o || consume)) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ack_i) begin
                    req_d     = 1'b0;
                    discard_d = 1'b0;
                    state_d   = ST_FETCH;
                    if (!discard_q && !redirect) begin
                        valid_d  = 1'b1;
                        instr_d  = imem_rdata_i;
                        pc_out_d = imem_addr_o;
                        pc_d     = imem_addr_o + XLEN'(4);
                    end
                end else if (redirect) begin
                    // request cannot be withdrawn; its data is dropped on ack
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (redirect) begin
            pc_d    = target;
            valid_d = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            discard_q     <= 1'b0;
            imem_req_o    <= 1'b0;
            imem_addr_o   <= RESET_PC;
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            pc_o          <= '0;
            flush_o       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            discard_q     <= discard_d;
            imem_req_o    <= req_d;
            imem_addr_o   <= addr_d;
            instr_valid_o <= valid_d;
            instr_o       <= instr_d;
            pc_o          <= pc_out_d;
            flush_o       <= flush_d;
        end
    end

`ifdef PC_FETCH_BRCNT_EN
    // Saturating count of taken redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_o <= '0;
        end else if (redirect && (taken_cnt_o != '1)) begin
            taken_cnt_o <= taken_cnt_o + XLEN'(1);
        end
    end
`else
    assign taken_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level model of the fetch stream.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk, rst_n, stall_i, br_valid_i, branch_i, cmp_i;
    logic [31:0] br_pc_i, br_offset_i;
    logic        imem_req_o, imem_ack_i, instr_valid_o, flush_o;
    logic [31:0] imem_addr_o, imem_rdata_i, instr_o, pc_o, taken_cnt_o;

    int checks = 0;
    int errors = 0;

    bit          mem_rand;
    int          mem_delay;
    logic [31:0] slow_addr;
    int          slow_delay;
    int          mem_cnt;
    bit          mem_busy;

    pc_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .br_valid_i   (br_valid_i),
        .branch_i     (branch_i),
        .cmp_i        (cmp_i),
        .br_pc_i      (br_pc_i),
        .br_offset_i  (br_offset_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .instr_valid_o(instr_valid_o),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .flush_o      (flush_o),
        .taken_cnt_o  (taken_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: acks a visible request after a per-request delay.
    initial begin
        imem_ack_i   = 1'b0;
        imem_rdata_i = '0;
        mem_busy     = 1'b0;
        mem_cnt      = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !imem_req_o) begin
                imem_ack_i = 1'b0;
                mem_busy   = 1'b0;
            end else begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    if (imem_addr_o == slow_addr) mem_cnt = slow_delay;
                    else if (mem_rand)            mem_cnt = int'($urandom_range(3, 0));
                    else                          mem_cnt = mem_delay;
                end
                if (mem_cnt == 0) begin
                    imem_ack_i   = 1'b1;
                    imem_rdata_i = mem_word(imem_addr_o);
                    mem_busy     = 1'b0;
                end else begin
                    imem_ack_i = 1'b0;
                    mem_cnt--;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input bit stall);
        @(negedge clk);
        rst_n       = 1'b0;
        stall_i     = stall;
        br_valid_i  = 1'b0;
        branch_i    = 1'b0;
        cmp_i       = 1'b0;
        br_pc_i     = '0;
        br_offset_i = '0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, flush_o, taken_cnt_o} !==
            {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_values got req=%0b addr=%h v=%0b instr=%h pc=%h flush=%0b cnt=%h",
                     imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, flush_o, taken_cnt_o);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] qa[$];
        logic [31:0] qp[$];
        logic [95:0] got;
        mem_delay = 0;
        do_reset(1'b0);
        checks++;
        if (imem_req_o !== 1'b0) begin
            errors++; $display("FAIL boot_req got %0b want 0", imem_req_o);
        end
        tick();
        checks++;
        if (imem_req_o !== 1'b0) begin
            errors++; $display("FAIL boot_exit_req got %0b want 0", imem_req_o);
        end
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 0) begin
                checks++;
                if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0}) begin
                    errors++; $display("FAIL first_req got req=%0b addr=%h want 1/0", imem_req_o, imem_addr_o);
                end
            end
            if (imem_req_o && imem_ack_i) qa.push_back(imem_addr_o);
            if (instr_valid_o) begin
                qp.push_back(pc_o);
                checks++;
                if (instr_o !== mem_word(pc_o)) begin
                    errors++; $display("FAIL t1_instr pc=%h got %h want %h", pc_o, instr_o, mem_word(pc_o));
                end
            end
        end
        got = (qa.size() >= 3) ? {qa[0], qa[1], qa[2]} : '1;
        checks++;
        if (got !== {32'h0, 32'h4, 32'h8}) begin
            errors++; $display("FAIL t1_req_addrs got %h want 000000000000000400000008", got);
        end
        got = (qp.size() >= 3) ? {qp[0], qp[1], qp[2]} : '1;
        checks++;
        if (got !== {32'h0, 32'h4, 32'h8}) begin
            errors++; $display("FAIL t1_pc_seq got %h want 000000000000000400000008", got);
        end
        checks++;
        if (qa.size() != 7) begin
            errors++; $display("FAIL t1_throughput got %0d fetches want 7", qa.size());
        end
    endtask

    task automatic test_wait_hold();
        bit found = 1'b0;
        mem_delay  = 0;
        slow_addr  = 32'h10;
        slow_delay = 3;
        do_reset(1'b0);
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (imem_req_o && imem_addr_o == 32'h10) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL t2_reach got no request at 0x10 want one");
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h10}) begin
                errors++; $display("FAIL t2_hold cyc=%0d got req=%0b addr=%h want 1/10", i, imem_req_o, imem_addr_o);
            end
        end
        tick();
        checks++;
        if ({instr_valid_o, pc_o, instr_o, imem_req_o} !== {1'b1, 32'h10, mem_word(32'h10), 1'b0}) begin
            errors++;
            $display("FAIL t2_deliver got v=%0b pc=%h instr=%h req=%0b want 1/10/%h/0",
                     instr_valid_o, pc_o, instr_o, imem_req_o, mem_word(32'h10));
        end
        tick();
        checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h14}) begin
            errors++; $display("FAIL t2_next_req got req=%0b addr=%h want 1/14", imem_req_o, imem_addr_o);
        end
        slow_addr = '1;
    endtask

    task automatic test_redirect_idle();
        bit found = 1'b0;
        do_reset(1'b1);
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (instr_valid_o) found = 1'b1;
        end
        tick();
        checks++;
        if ({imem_req_o, instr_valid_o, pc_o} !== {1'b0, 1'b1, 32'h0}) begin
            errors++; $display("FAIL t3_idle got req=%0b v=%0b pc=%h want 0/1/0", imem_req_o, instr_valid_o, pc_o);
        end
        br_valid_i = 1'b1; branch_i = 1'b1; cmp_i = 1'b1;
        br_pc_i = 32'h20; br_offset_i = 32'hFFFF_FFFC;
        tick();
        checks++;
        if ({flush_o, instr_valid_o, imem_req_o} !== 3'b100) begin
            errors++; $display("FAIL t3_flush got flush=%0b v=%0b req=%0b want 1/0/0", flush_o, instr_valid_o, imem_req_o);
        end
        br_valid_i = 1'b0; stall_i = 1'b0;
        tick();
        checks++;
        if ({flush_o, imem_req_o, imem_addr_o} !== {1'b0, 1'b1, 32'h10}) begin
            errors++; $display("FAIL t3_target got flush=%0b req=%0b addr=%h want 0/1/10", flush_o, imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_redirect_wait();
        bit found = 1'b0;
        bit bad = 1'b0;
        bit got_req = 1'b0;
        logic [31:0] first = '1;
        slow_addr  = 32'h40;
        slow_delay = 2;
        do_reset(1'b0);
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (imem_req_o && imem_addr_o == 32'h40) found = 1'b1;
        end
        br_valid_i = 1'b1; branch_i = 1'b1; cmp_i = 1'b1;
        br_pc_i = 32'h100; br_offset_i = 32'h0;
        tick();
        checks++;
        if ({flush_o, imem_req_o, imem_addr_o} !== {1'b1, 1'b1, 32'h40}) begin
            errors++; $display("FAIL t4_flush_hold got flush=%0b req=%0b addr=%h want 1/1/40", flush_o, imem_req_o, imem_addr_o);
        end
        br_valid_i = 1'b0;
        tick();
        checks++;
        if (flush_o !== 1'b0) begin
            errors++; $display("FAIL t4_flush_once got %0b want 0", flush_o);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (instr_valid_o && pc_o == 32'h40) bad = 1'b1;
            if (!got_req && imem_req_o) begin
                got_req = 1'b1;
                first   = imem_addr_o;
            end
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL t4_discard got pc_o=40 delivered want dropped");
        end
        checks++;
        if (first !== 32'h100) begin
            errors++; $display("FAIL t4_next_req got %h want 00000100", first);
        end
        slow_addr = '1;
    endtask

    task automatic test_stall();
        bit found = 1'b0;
        do_reset(1'b0);
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (instr_valid_o && pc_o == 32'h8) found = 1'b1;
        end
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({instr_valid_o, pc_o, instr_o, imem_req_o} !== {1'b1, 32'h8, mem_word(32'h8), 1'b0}) begin
                errors++;
                $display("FAIL t5_hold cyc=%0d got v=%0b pc=%h instr=%h req=%0b want 1/8/%h/0",
                         i, instr_valid_o, pc_o, instr_o, imem_req_o, mem_word(32'h8));
            end
        end
        stall_i = 1'b0;
        tick();
        checks++;
        if ({imem_req_o, imem_addr_o, instr_valid_o} !== {1'b1, 32'hC, 1'b0}) begin
            errors++; $display("FAIL t5_release got req=%0b addr=%h v=%0b want 1/c/0", imem_req_o, imem_addr_o, instr_valid_o);
        end
    endtask

    task automatic test_counter();
        logic [17:0] tbl = 18'b111_110_111_101_011_111;
        logic [31:0] exp_cnt;
        bit found = 1'b0;
        bit exp_t;
        do_reset(1'b1);
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (instr_valid_o) found = 1'b1;
        end
        for (int k = 0; k < 6; k++) begin
            {br_valid_i, branch_i, cmp_i} = tbl[3*k +: 3];
            br_pc_i     = $urandom;
            br_offset_i = $urandom;
            exp_t       = &tbl[3*k +: 3];
            tick();
            checks++;
            if (flush_o !== exp_t) begin
                errors++; $display("FAIL t6_flush k=%0d got %0b want %0b", k, flush_o, exp_t);
            end
        end
        br_valid_i = 1'b0;
        tick();
`ifdef PC_FETCH_BRCNT_EN
        exp_cnt = 32'd3;
`else
        exp_cnt = 32'd0;
`endif
        checks++;
        if (taken_cnt_o !== exp_cnt) begin
            errors++; $display("FAIL t6_count got %0d want %0d", taken_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        slow_addr  = 32'h4;
        slow_delay = 5;
        do_reset(1'b0);
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_req_o && imem_addr_o == 32'h4) found = 1'b1;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, flush_o, taken_cnt_o} !==
            {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL mid_reset got req=%0b addr=%h v=%0b instr=%h pc=%h flush=%0b cnt=%h",
                     imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, flush_o, taken_cnt_o);
        end
        slow_addr = '1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, RESET_PC}) begin
            errors++; $display("FAIL mid_reset_restart got req=%0b addr=%h want 1/%h", imem_req_o, imem_addr_o, RESET_PC);
        end
    endtask

    // Random traffic against a model of the fetch stream: which address is fetched next,
    // which fetches reach decode, and what the buffer must hold.
    task automatic test_random();
        logic [31:0] exp_next = RESET_PC;
        logic [31:0] out_addr = '0;
        bit          outstanding = 1'b0;
        bit          dead = 1'b0;
        bit          p_req = 1'b0, p_ack = 1'b0, p_valid = 1'b0, p_stall = 1'b0, p_taken = 1'b0;
        logic [31:0] p_addr = '0, p_instr = '0, p_pc = '0, p_target = '0;
        bit          exp_req;
        int          n_taken = 0;
        int          delivered = 0;
        logic [31:0] exp_cnt;
        mem_rand = 1'b1;
        do_reset(1'b0);
        tick();
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            checks++;
            if (flush_o !== p_taken) begin
                errors++; $display("FAIL rnd_flush cyc=%0d got %0b want %0b", cyc, flush_o, p_taken);
            end
            if (p_ack) begin
                outstanding = 1'b0;
                if (!dead && !p_taken) begin
                    checks++;
                    if ({instr_valid_o, pc_o, instr_o} !== {1'b1, out_addr, mem_word(out_addr)}) begin
                        errors++;
                        $display("FAIL rnd_deliver cyc=%0d got v=%0b pc=%h instr=%h want 1/%h/%h",
                                 cyc, instr_valid_o, pc_o, instr_o, out_addr, mem_word(out_addr));
                    end
                    exp_next = out_addr + 32'd4;
                    delivered++;
                end else begin
                    checks++;
                    if (instr_valid_o !== 1'b0) begin
                        errors++; $display("FAIL rnd_drop cyc=%0d got v=%0b pc=%h want v=0", cyc, instr_valid_o, pc_o);
                    end
                end
            end else if (!p_taken && p_valid && p_stall) begin
                checks++;
                if ({instr_valid_o, pc_o, instr_o} !== {1'b1, p_pc, p_instr}) begin
                    errors++;
                    $display("FAIL rnd_stall_hold cyc=%0d got v=%0b pc=%h instr=%h want 1/%h/%h",
                             cyc, instr_valid_o, pc_o, instr_o, p_pc, p_instr);
                end
            end else begin
                checks++;
                if (instr_valid_o !== 1'b0) begin
                    errors++; $display("FAIL rnd_empty cyc=%0d got v=%0b want 0", cyc, instr_valid_o);
                end
            end
            if (p_taken) begin
                exp_next = p_target;
                if (outstanding) dead = 1'b1;
            end
            if (p_req) exp_req = !p_ack;
            else       exp_req = !p_taken && (!p_valid || !p_stall);
            checks++;
            if (imem_req_o !== exp_req) begin
                errors++; $display("FAIL rnd_req cyc=%0d got %0b want %0b", cyc, imem_req_o, exp_req);
            end
            if (imem_req_o && p_req && !p_ack) begin
                checks++;
                if (imem_addr_o !== p_addr) begin
                    errors++; $display("FAIL rnd_addr_hold cyc=%0d got %h want %h", cyc, imem_addr_o, p_addr);
                end
            end else if (imem_req_o) begin
                checks++;
                if (imem_addr_o !== exp_next) begin
                    errors++; $display("FAIL rnd_addr cyc=%0d got %h want %h", cyc, imem_addr_o, exp_next);
                end
                outstanding = 1'b1;
                out_addr    = imem_addr_o;
                dead        = 1'b0;
            end
            p_req   = imem_req_o;
            p_addr  = imem_addr_o;
            p_ack   = imem_ack_i;
            p_valid = instr_valid_o;
            p_instr = instr_o;
            p_pc    = pc_o;
            stall_i     = ($urandom_range(99, 0) < 30);
            br_valid_i  = ($urandom_range(99, 0) < 15);
            branch_i    = 1'($urandom);
            cmp_i       = 1'($urandom);
            br_pc_i     = $urandom;
            br_offset_i = $urandom;
            p_stall  = stall_i;
            p_taken  = br_valid_i && branch_i && cmp_i;
            p_target = br_pc_i + br_offset_i * 32'd4;
            if (p_taken) n_taken++;
        end
        br_valid_i = 1'b0;
        stall_i    = 1'b0;
        tick();
        mem_rand = 1'b0;
`ifdef PC_FETCH_BRCNT_EN
        exp_cnt = 32'(n_taken);
`else
        exp_cnt = 32'd0;
`endif
        checks++;
        if (taken_cnt_o !== exp_cnt) begin
            errors++; $display("FAIL rnd_count got %0d want %0d", taken_cnt_o, exp_cnt);
        end
        checks++;
        if (delivered < 20) begin
            errors++; $display("FAIL rnd_progress got %0d deliveries want at least 20", delivered);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        stall_i     = 1'b0;
        br_valid_i  = 1'b0;
        branch_i    = 1'b0;
        cmp_i       = 1'b0;
        br_pc_i     = '0;
        br_offset_i = '0;
        mem_rand    = 1'b0;
        mem_delay   = 0;
        slow_addr   = '1;
        slow_delay  = 0;
        test_reset();
        test_zero_wait();
        test_wait_hold();
        test_redirect_idle();
        test_redirect_wait();
        test_stall();
        test_counter();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
